// File: rtl/vga_v_sync_gen.sv
// Vertical half of the VGA timing generator: counts lines on rising edges of the
// line-end trigger and registers sync, blanking and pixel-coordinate outputs.
module vga_v_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_count_i,
  input  logic       trig_v_i,
  output logic [9:0] v_count_o,
  output logic [1:0] v_state_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o,
  output logic [9:0] pixel_x_o,
  output logic [9:0] pixel_y_o,
  output logic       frame_start_o,
  output logic       h_err_o
);

  localparam logic [9:0] H_TOTAL     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS       = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_FRONT_BEG = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_BACK_BEG  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } vstate_e;

  vstate_e    state_q;
  logic [9:0] v_count_q, v_count_d;
  logic       trig_q;
  logic       rise, v_wrap;
  logic       h_vis, h_in_sync, h_oob, vis_d;
  logic       hsync_q, vsync_q, video_on_q, frame_start_q, h_err_q;
  logic [9:0] pixel_x_q, pixel_y_q;

  always_comb begin
    rise      = trig_v_i & ~trig_q;
    v_wrap    = (v_count_q == V_LAST);
    v_count_d = v_count_q;
    if (rise) v_count_d = v_wrap ? 10'd0 : v_count_q + 10'd1;
    h_oob     = (h_count_i >= H_TOTAL);
    h_vis     = (h_count_i < H_VIS);
    // out-of-range positions sit above the sync window, so they read as blanking
    h_in_sync = (h_count_i >= H_SYNC_BEG) && (h_count_i <= H_SYNC_END);
    vis_d     = h_vis && (state_q == ST_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ACTIVE;
      v_count_q     <= '0;
      trig_q        <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
      h_err_q       <= 1'b0;
    end else begin
      trig_q        <= trig_v_i;
      v_count_q     <= v_count_d;
      frame_start_q <= rise & v_wrap;
      if (rise) begin
        case (state_q)
          ST_ACTIVE: if (v_count_d == V_FRONT_BEG) state_q <= ST_FRONT;
          ST_FRONT:  if (v_count_d == V_SYNC_BEG)  state_q <= ST_SYNC;
          ST_SYNC:   if (v_count_d == V_BACK_BEG)  state_q <= ST_BACK;
          ST_BACK:   if (v_count_d == 10'd0)       state_q <= ST_ACTIVE;
          default:                                 state_q <= ST_ACTIVE;
        endcase
      end
      // outputs reflect the line register before this edge's increment
      hsync_q    <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync_q    <= (state_q == ST_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      video_on_q <= vis_d;
      pixel_x_q  <= vis_d ? h_count_i : 10'd0;
      pixel_y_q  <= vis_d ? v_count_q : 10'd0;
      h_err_q    <= h_err_q | h_oob;
    end
  end

  assign v_count_o     = v_count_q;
  assign v_state_o     = state_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_on_q;
  assign pixel_x_o     = pixel_x_q;
  assign pixel_y_o     = pixel_y_q;
  assign frame_start_o = frame_start_q;
  assign h_err_o       = h_err_q;

endmodule

// File: tb/tb_vga_v_sync_gen.sv
// Bench for vga_v_sync_gen: a boundary vector table, an 800-pixel line sweep and
// randomized frames checked cycle by cycle against an arithmetic timing model.
module tb_vga_v_sync_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] h_count = '0;
  logic       trig_v = 1'b0;
  logic [9:0] v_count_o, pixel_x_o, pixel_y_o;
  logic [1:0] v_state_o;
  logic       hsync_o, vsync_o, video_on_o, frame_start_o, h_err_o;

  int checks = 0;
  int errors = 0;

  // reference model: line number, previous trigger level, sticky error
  int m_v = 0;
  int m_trig = 0;
  int m_herr = 0;

  vga_v_sync_gen dut (
    .clk(clk), .rst(rst), .h_count_i(h_count), .trig_v_i(trig_v),
    .v_count_o(v_count_o), .v_state_o(v_state_o), .hsync_o(hsync_o),
    .vsync_o(vsync_o), .video_on_o(video_on_o), .pixel_x_o(pixel_x_o),
    .pixel_y_o(pixel_y_o), .frame_start_o(frame_start_o), .h_err_o(h_err_o)
  );

  always #20 clk = ~clk;

  typedef struct {
    int h;
    int hs;
    int vo;
    int px;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (model line %0d)", name, act, exp, m_v);
    end
  endtask

  function automatic int region(input int v);
    if (v < 480) return 0;
    if (v < 490) return 1;
    if (v < 492) return 2;
    return 3;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_v"},     int'(v_count_o), 0);
    chk({tag, "_st"},    int'(v_state_o), 0);
    chk({tag, "_hs"},    int'(hsync_o), 1);
    chk({tag, "_vs"},    int'(vsync_o), 1);
    chk({tag, "_vo"},    int'(video_on_o), 0);
    chk({tag, "_px"},    int'(pixel_x_o), 0);
    chk({tag, "_py"},    int'(pixel_y_o), 0);
    chk({tag, "_fs"},    int'(frame_start_o), 0);
    chk({tag, "_herr"},  int'(h_err_o), 0);
  endtask

  // one clock with the given inputs, then compare every output to the model
  task automatic step(input int h, input bit t);
    int e_hs, e_vs, e_vo, e_px, e_py, e_fs, rise;
    h_count = 10'(h);
    trig_v  = t;
    @(posedge clk);
    #1;
    rise = (t && m_trig == 0) ? 1 : 0;
    e_hs = (h >= 656 && h <= 751) ? 0 : 1;
    e_vs = (region(m_v) == 2) ? 0 : 1;
    e_vo = (h < 640 && region(m_v) == 0) ? 1 : 0;
    e_px = e_vo ? h : 0;
    e_py = e_vo ? m_v : 0;
    e_fs = (rise == 1 && m_v == 524) ? 1 : 0;
    if (h >= 800) m_herr = 1;
    if (rise == 1) m_v = (m_v + 1) % 525;
    m_trig = t ? 1 : 0;
    chk("v_count",  int'(v_count_o), m_v);
    chk("v_state",  int'(v_state_o), region(m_v));
    chk("hsync",    int'(hsync_o), e_hs);
    chk("vsync",    int'(vsync_o), e_vs);
    chk("video_on", int'(video_on_o), e_vo);
    chk("pixel_x",  int'(pixel_x_o), e_px);
    chk("pixel_y",  int'(pixel_y_o), e_py);
    chk("frame_st", int'(frame_start_o), e_fs);
    chk("h_err",    int'(h_err_o), m_herr);
  endtask

  initial begin
    vec_t tbl[9];
    int hs_cnt, hs_first, fs_cnt, guard, hold;
    bit seen480;

    tbl[0] = '{h: 0,   hs: 1, vo: 1, px: 0};
    tbl[1] = '{h: 639, hs: 1, vo: 1, px: 639};
    tbl[2] = '{h: 640, hs: 1, vo: 0, px: 0};
    tbl[3] = '{h: 655, hs: 1, vo: 0, px: 0};
    tbl[4] = '{h: 656, hs: 0, vo: 0, px: 0};
    tbl[5] = '{h: 751, hs: 0, vo: 0, px: 0};
    tbl[6] = '{h: 752, hs: 1, vo: 0, px: 0};
    tbl[7] = '{h: 799, hs: 1, vo: 0, px: 0};
    tbl[8] = '{h: 320, hs: 1, vo: 1, px: 320};

    // reset held 3 clocks; values must be present while rst is high
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    rst = 1'b0;

    // boundary vectors on line 0, no trigger
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].h, 1'b0);
      chk($sformatf("tbl%0d_hs", i), int'(hsync_o), tbl[i].hs);
      chk($sformatf("tbl%0d_vo", i), int'(video_on_o), tbl[i].vo);
      chk($sformatf("tbl%0d_px", i), int'(pixel_x_o), tbl[i].px);
      chk($sformatf("tbl%0d_py", i), int'(pixel_y_o), 0);
    end

    // a full 800-pixel line: hsync pulse width and position
    hs_cnt = 0;
    hs_first = -1;
    for (int h = 0; h < 800; h++) begin
      step(h, 1'b0);
      if (hsync_o == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = h;
      end
    end
    chk("hs_low_count", hs_cnt, 96);
    chk("hs_first_low", hs_first, 656);

    // one full frame of compressed lines, trigger held 1..3 clocks
    fs_cnt = 0;
    seen480 = 1'b0;
    for (int line = 0; line < 525; line++) begin
      for (int k = 0; k < 2; k++) begin
        step($urandom_range(0, 799), 1'b0);
        fs_cnt += int'(frame_start_o);
      end
      hold = $urandom_range(1, 3);
      for (int k = 0; k < hold; k++) begin
        step($urandom_range(0, 799), 1'b1);
        fs_cnt += int'(frame_start_o);
        if (m_v == 480 && !seen480) begin
          seen480 = 1'b1;
          chk("st_at_480", int'(v_state_o), 1);
        end
      end
    end
    step($urandom_range(0, 799), 1'b0);
    fs_cnt += int'(frame_start_o);
    chk("frame_start_count", fs_cnt, 1);
    chk("frame_end_v", int'(v_count_o), 0);
    chk("seen_480", int'(seen480), 1);

    // out-of-range h_count: blanked outputs and sticky error
    step(639, 1'b0);
    step(800, 1'b0);
    chk("oob_herr", int'(h_err_o), 1);
    chk("oob_vo", int'(video_on_o), 0);
    chk("oob_hs", int'(hsync_o), 1);
    step($urandom_range(801, 1023), 1'b0);
    for (int k = 0; k < 3; k++) step($urandom_range(0, 799), 1'b0);
    chk("herr_sticky", int'(h_err_o), 1);

    // advance to line 300, then reset between clock edges
    guard = 0;
    while (m_v != 300 && guard < 2000) begin
      step($urandom_range(0, 799), 1'b1);
      step($urandom_range(0, 799), 1'b0);
      guard++;
    end
    chk("reach_300", m_v, 300);
    h_count = 10'd100;
    trig_v  = 1'b1;
    #5;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    m_v = 0;
    m_trig = 0;
    m_herr = 0;
    repeat (2) @(posedge clk);
    trig_v = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("rst_mid_hold");
    rst = 1'b0;
    step(10, 1'b0);
    step(20, 1'b1);
    chk("post_rst_v", int'(v_count_o), 1);
    chk("post_rst_fs", int'(frame_start_o), 0);
    for (int k = 0; k < 20; k++) step($urandom_range(0, 1023) % 800, k[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
